tile_loader: RTL and testbench
==============================

TILE_LOADER -- requirements
Module: tile_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width.
REQ-002 SHALL have parameter HEIGHT, default 32: words per burst, equal to the tile buffer depth.
REQ-003 SHALL have parameter N_TILES, default 4: number of requesting tiles.
REQ-004 SHALL have parameter AW, default $clog2(N_TILES*HEIGHT): source address width.
REQ-005 Port list SHALL be the following (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_in  in  N_TILES  per-tile input-operand request, level
- req_w  in  N_TILES  per-tile weight-operand request, level
- grant_in  out  N_TILES  one-hot input write grant
- grant_w  out  N_TILES  one-hot weight write grant
- data_in_a  out  WIDTH  input word, shared by all tiles
- data_in_b  out  WIDTH  weight word, shared by all tiles
- src_a_addr  out  AW  input source memory address
- src_a_rd  out  1  input source read strobe
- src_a_data  in  WIDTH  input source read data, 1-cycle latency
- src_b_addr  out  AW  weight source memory address
- src_b_rd  out  1  weight source read strobe
- src_b_data  in  WIDTH  weight source read data, 1-cycle latency
- busy_a, busy_b  out  1  channel not in IDLE
- burst_done_a, burst_done_b  out  1  single-cycle pulse on the last grant cycle

Function
REQ-006 Channel A (req_in, grant_in, src_a, data_in_a) and channel B (req_w, grant_w, src_b, data_in_b) SHALL operate fully independently with identical behaviour; the REQs below describe one channel.
REQ-007 Channel FSM states SHALL be IDLE, STREAM, GAP.
REQ-008 In IDLE with any req bit high, the channel SHALL select winner w by round-robin.
- Search starts at last_winner+1, modulo N_TILES.
- last_winner resets to N_TILES-1, so tile 0 has first priority.
REQ-009 In the same IDLE cycle the channel SHALL drive src_addr = w*HEIGHT and src_rd = 1, and go to STREAM.
REQ-010 STREAM SHALL last exactly HEIGHT cycles, indexed n = 0..HEIGHT-1:
- grant[w] = 1;
- data = src_data (the word at w*HEIGHT+n);
- for n < HEIGHT-1, src_addr = w*HEIGHT+n+1 and src_rd = 1;
- at n = HEIGHT-1, src_rd = 0.
REQ-011 Latency SHALL be: req sampled in IDLE at cycle t, first grant at t+1, last grant at t+HEIGHT.
REQ-012 burst_done SHALL pulse on STREAM cycle n = HEIGHT-1; the FSM then goes to GAP.
REQ-013 GAP SHALL last one cycle with all grants 0, then return to IDLE.
- A tile's req is ignored in GAP, so it can drop req after its last grant.
- The minimum spacing between bursts is therefore 2 cycles (GAP + IDLE).
REQ-014 grant SHALL be one-hot or zero at all times; data output SHALL be 0 whenever no grant bit is set.
REQ-015 Request bits that change during STREAM SHALL have no effect; a dropped winner req SHALL NOT shorten the burst.
REQ-016 The burst counter SHALL be $clog2(HEIGHT)+1 bits and SHALL NOT wrap inside a burst; the address SHALL never exceed N_TILES*HEIGHT-1.
REQ-017 Simultaneous A and B bursts to the same tile SHALL be permitted, since the tile writes them on separate RAM ports.
REQ-018 busy SHALL be 1 in STREAM and GAP.

Reset
REQ-019 On rst = 0, asynchronously, the loader SHALL set:
- FSM to IDLE;
- all grants, src_rd, busy and burst_done to 0;
- src_addr and data outputs to 0;
- last_winner to N_TILES-1.
REQ-020 Reset asserted mid-burst SHALL abort the burst with no further grant; after release, service SHALL restart from IDLE with tile 0 priority.

Structure
REQ-021 A shared package SHALL hold the state enum (IDLE, STREAM, GAP) and a round-robin pick function.
REQ-022 The per-channel engine SHALL be one sub-module, load_channel, instantiated twice (A and B); tile_loader is wiring only.

Verification
REQ-023 Single request, WIDTH = 16, HEIGHT = 32, N_TILES = 4:
- Stimulus: req_in = 0001 at cycle 5; src_a returns data = address.
- Required: grant_in = 0001 for cycles 6..37; data_in_a = 0..31; burst_done_a at 37; busy_a 0 from 39.
REQ-024 Round-robin:
- Stimulus: req_w = 1111 held.
- Required: grants in order 0001, 0010, 0100, 1000, 0001; each 32 cycles; 2-cycle gaps; tile k receives words k*32..k*32+31.
REQ-025 Independent channels:
- Stimulus: req_in = 0100 and req_w = 0100 in the same cycle.
- Required: grant_in and grant_w both 0100 over identical cycles; data_in_a = src_a_data and data_in_b = src_b_data.
REQ-026 Request drop mid-burst:
- Stimulus: req_in = 0010 raised, then dropped at burst cycle 10.
- Required: grant_in stays 0010 for the full 32 cycles, then no further grant.
REQ-027 Reset mid-burst:
- Stimulus: rst = 0 at burst cycle 15.
- Required: grant 0 in the same cycle (asynchronous); after release with req_in = 1010, the first grant is 0010.

Source files
------------

// File: rtl/tile_loader_pkg.sv
// Shared types and helpers for the tile loader: channel FSM states and
// the round-robin winner search used by each load channel.
package tile_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP
    } state_t;

    // Widest request vector the round-robin helper accepts.
    localparam int MAX_TILES = 32;

    // Returns the first asserted request strictly after 'last', wrapping
    // modulo n_tiles; returns 'last' itself when no request is asserted.
    function automatic int unsigned rr_pick(
        input logic [MAX_TILES-1:0] req,
        input int unsigned          last,
        input int unsigned          n_tiles
    );
        int unsigned idx;
        int unsigned pick;
        logic        found;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_TILES; i++) begin
            if (!found && (i <= n_tiles)) begin
                idx = last + i;
                if (idx >= n_tiles) begin
                    idx = idx - n_tiles;
                end
                if (req[idx[4:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tile_loader_channel.sv
// One burst engine: round-robin arbitration over tile requests, then a
// HEIGHT-word stream from source memory to the granted tile, then a gap.
module load_channel
    import tile_loader_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int HEIGHT  = 32,
    parameter int N_TILES = 4,
    parameter int AW      = $clog2(N_TILES*HEIGHT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_TILES-1:0] i_req,
    output logic [N_TILES-1:0] o_grant,
    output logic [WIDTH-1:0]   o_data,
    output logic [AW-1:0]      o_src_addr,
    output logic               o_src_rd,
    input  logic [WIDTH-1:0]   i_src_data,
    output logic               o_busy,
    output logic               o_burst_done
);

    localparam int              WW           = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    localparam int              CW           = $clog2(HEIGHT) + 1;
    localparam logic [CW-1:0]   LAST_N       = CW'(HEIGHT - 1);
    localparam logic [WW-1:0]   RESET_WINNER = WW'(N_TILES - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_next_cnt;
    // r_winner doubles as last_winner: it holds the tile being served and,
    // once the burst is over, the starting point of the next search.
    logic [WW-1:0] r_winner;
    logic [WW-1:0] w_next_winner;
    logic [WW-1:0] w_pick;
    logic [AW-1:0] w_pick_base;
    logic [AW-1:0] w_win_base;

    assign w_pick      = WW'(rr_pick(MAX_TILES'(i_req), 32'(r_winner), N_TILES));
    assign w_pick_base = AW'(32'(w_pick) * HEIGHT);
    assign w_win_base  = AW'(32'(r_winner) * HEIGHT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_winner <= RESET_WINNER;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_winner <= w_next_winner;
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default before the
        // case statement, so no path through the block can infer a latch.
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_next_winner = r_winner;
        o_grant       = '0;
        o_src_addr    = '0;
        o_src_rd      = 1'b0;
        o_burst_done  = 1'b0;

        case (r_state)
            IDLE: begin
                if (|i_req) begin
                    w_next_winner = w_pick;
                    w_next_cnt    = '0;
                    w_next_state  = STREAM;
                    o_src_addr    = w_pick_base;
                    o_src_rd      = 1'b1;
                end
            end
            STREAM: begin
                o_grant[r_winner] = 1'b1;
                if (r_cnt == LAST_N) begin
                    o_burst_done = 1'b1;
                    w_next_state = GAP;
                end else begin
                    o_src_addr = w_win_base + AW'(r_cnt) + AW'(1);
                    o_src_rd   = 1'b1;
                    w_next_cnt = r_cnt + CW'(1);
                end
            end
            GAP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // NOTE: the IDLE read request is combinational from i_req, so it is
        // qualified with reset to keep the source port quiet while in reset.
        if (!rst_n) begin
            o_src_rd   = 1'b0;
            o_src_addr = '0;
        end
    end

    assign o_data = (r_state == STREAM) ? i_src_data : '0;
    assign o_busy = (r_state != IDLE);

endmodule

// File: rtl/tile_loader.sv
// Two independent load channels: A streams input operands, B streams
// weights. This level only wires the channels to the named ports.
module tile_loader
    import tile_loader_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int HEIGHT  = 32,
    parameter int N_TILES = 4,
    parameter int AW      = $clog2(N_TILES*HEIGHT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_TILES-1:0] req_in,
    input  logic [N_TILES-1:0] req_w,
    output logic [N_TILES-1:0] grant_in,
    output logic [N_TILES-1:0] grant_w,
    output logic [WIDTH-1:0]   data_in_a,
    output logic [WIDTH-1:0]   data_in_b,
    output logic [AW-1:0]      src_a_addr,
    output logic               src_a_rd,
    input  logic [WIDTH-1:0]   src_a_data,
    output logic [AW-1:0]      src_b_addr,
    output logic               src_b_rd,
    input  logic [WIDTH-1:0]   src_b_data,
    output logic               busy_a,
    output logic               busy_b,
    output logic               burst_done_a,
    output logic               burst_done_b
);

    load_channel #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .N_TILES (N_TILES),
        .AW      (AW)
    ) u_chan_a (
        .clk          (clk),
        .rst_n        (rst),
        .i_req        (req_in),
        .o_grant      (grant_in),
        .o_data       (data_in_a),
        .o_src_addr   (src_a_addr),
        .o_src_rd     (src_a_rd),
        .i_src_data   (src_a_data),
        .o_busy       (busy_a),
        .o_burst_done (burst_done_a)
    );

    load_channel #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .N_TILES (N_TILES),
        .AW      (AW)
    ) u_chan_b (
        .clk          (clk),
        .rst_n        (rst),
        .i_req        (req_w),
        .o_grant      (grant_w),
        .o_data       (data_in_b),
        .o_src_addr   (src_b_addr),
        .o_src_rd     (src_b_rd),
        .i_src_data   (src_b_data),
        .o_busy       (busy_b),
        .o_burst_done (burst_done_b)
    );

endmodule

// File: tb/tb_tile_loader.sv
// Scoreboard bench for tile_loader: stimulus pushes expected grant cycles,
// a per-channel monitor pops and compares on every granted cycle.
module tb_tile_loader;

    localparam int WIDTH   = 16;
    localparam int HEIGHT  = 32;
    localparam int N_TILES = 4;
    localparam int AW      = $clog2(N_TILES*HEIGHT);

    logic               clk = 1'b0;
    logic               rst;
    logic [N_TILES-1:0] req_in;
    logic [N_TILES-1:0] req_w;
    logic [N_TILES-1:0] grant_in;
    logic [N_TILES-1:0] grant_w;
    logic [WIDTH-1:0]   data_in_a;
    logic [WIDTH-1:0]   data_in_b;
    logic [AW-1:0]      src_a_addr;
    logic               src_a_rd;
    logic [WIDTH-1:0]   src_a_data = '0;
    logic [AW-1:0]      src_b_addr;
    logic               src_b_rd;
    logic [WIDTH-1:0]   src_b_data = '0;
    logic               busy_a;
    logic               busy_b;
    logic               burst_done_a;
    logic               burst_done_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int                 cyc;
        logic [N_TILES-1:0] grant;
        logic [WIDTH-1:0]   data;
        logic               done;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    tile_loader #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .N_TILES (N_TILES),
        .AW      (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .req_w        (req_w),
        .grant_in     (grant_in),
        .grant_w      (grant_w),
        .data_in_a    (data_in_a),
        .data_in_b    (data_in_b),
        .src_a_addr   (src_a_addr),
        .src_a_rd     (src_a_rd),
        .src_a_data   (src_a_data),
        .src_b_addr   (src_b_addr),
        .src_b_rd     (src_b_rd),
        .src_b_data   (src_b_data),
        .busy_a       (busy_a),
        .busy_b       (busy_b),
        .burst_done_a (burst_done_a),
        .burst_done_b (burst_done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Source memories with 1-cycle read latency: A returns its address,
    // B returns its address offset by 0x1000.
    always @(posedge clk) begin
        if (src_a_rd) src_a_data <= 16'(src_a_addr);
        if (src_b_rd) src_b_data <= 16'(src_b_addr) + 16'h1000;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_burst(input bit ch_b, input int tile, input int req_cyc, input int n_words);
        exp_t e;
        for (int n = 0; n < n_words; n++) begin
            e.cyc   = req_cyc + 1 + n;
            e.grant = N_TILES'(1 << tile);
            e.data  = 16'(tile*HEIGHT + n) + (ch_b ? 16'h1000 : 16'h0000);
            e.done  = (n == HEIGHT-1);
            if (ch_b) q_b.push_back(e);
            else      q_a.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q_a.size() > 0 && q_a[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL a_grant_missing: expected grant at cycle %0d, now %0d", q_a[0].cyc, cyc);
            void'(q_a.pop_front());
        end
        if (src_a_rd) check("a_addr_range", 64'(src_a_addr <= AW'(N_TILES*HEIGHT-1)), 64'(1));
        if (grant_in != '0 || burst_done_a) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_grant", 64'(grant_in), 64'(0));
            end else begin
                e = q_a.pop_front();
                check("a_grant_cycle", 64'(cyc), 64'(e.cyc));
                check("a_grant", 64'(grant_in), 64'(e.grant));
                check("a_data", 64'(data_in_a), 64'(e.data));
                check("a_burst_done", 64'(burst_done_a), 64'(e.done));
            end
        end else begin
            check("a_idle_data", 64'(data_in_a), 64'(0));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        while (q_b.size() > 0 && q_b[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL b_grant_missing: expected grant at cycle %0d, now %0d", q_b[0].cyc, cyc);
            void'(q_b.pop_front());
        end
        if (src_b_rd) check("b_addr_range", 64'(src_b_addr <= AW'(N_TILES*HEIGHT-1)), 64'(1));
        if (grant_w != '0 || burst_done_b) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_grant", 64'(grant_w), 64'(0));
            end else begin
                e = q_b.pop_front();
                check("b_grant_cycle", 64'(cyc), 64'(e.cyc));
                check("b_grant", 64'(grant_w), 64'(e.grant));
                check("b_data", 64'(data_in_b), 64'(e.data));
                check("b_burst_done", 64'(burst_done_b), 64'(e.done));
            end
        end else begin
            check("b_idle_data", 64'(data_in_b), 64'(0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        req_in = '1;
        req_w  = '1;

        // Reset state, with requests asserted to confirm the read strobe stays low.
        wait_cycle(2);
        #1;
        check("rst_grant_in", 64'(grant_in), 64'(0));
        check("rst_grant_w", 64'(grant_w), 64'(0));
        check("rst_src_a_rd", 64'(src_a_rd), 64'(0));
        check("rst_src_b_rd", 64'(src_b_rd), 64'(0));
        check("rst_src_a_addr", 64'(src_a_addr), 64'(0));
        check("rst_busy", 64'({busy_a, busy_b}), 64'(0));
        check("rst_done", 64'({burst_done_a, burst_done_b}), 64'(0));
        req_in = '0;
        req_w  = '0;
        wait_cycle(3);
        rst = 1'b1;

        // Single request on A: grants 6..37, done at 37, idle from 39.
        wait_cycle(5);
        req_in = 4'b0001;
        push_burst(1'b0, 0, 5, HEIGHT);
        #1;
        check("t1_first_rd", 64'(src_a_rd), 64'(1));
        check("t1_first_addr", 64'(src_a_addr), 64'(0));
        wait_cycle(6);
        req_in = '0;
        #1;
        check("t1_second_addr", 64'(src_a_addr), 64'(1));
        wait_cycle(37);
        #1;
        check("t1_last_rd", 64'(src_a_rd), 64'(0));
        wait_cycle(38);
        check("t1_busy_gap", 64'(busy_a), 64'(1));
        wait_cycle(39);
        check("t1_busy_idle", 64'(busy_a), 64'(0));

        // Round-robin on B with all requests held: tiles 0,1,2,3,0, period 34.
        wait_cycle(45);
        req_w = 4'b1111;
        push_burst(1'b1, 0, 45, HEIGHT);
        push_burst(1'b1, 1, 79, HEIGHT);
        push_burst(1'b1, 2, 113, HEIGHT);
        push_burst(1'b1, 3, 147, HEIGHT);
        push_burst(1'b1, 0, 181, HEIGHT);
        wait_cycle(190);
        req_w = '0;

        // Both channels serve tile 2 over identical cycles.
        wait_cycle(230);
        req_in = 4'b0100;
        req_w  = 4'b0100;
        push_burst(1'b0, 2, 230, HEIGHT);
        push_burst(1'b1, 2, 230, HEIGHT);
        #1;
        check("t3_a_addr", 64'(src_a_addr), 64'(64));
        check("t3_b_addr", 64'(src_b_addr), 64'(64));
        wait_cycle(231);
        req_in = '0;
        req_w  = '0;

        // Winner drops its request at burst cycle 10: full burst, nothing after.
        wait_cycle(270);
        req_in = 4'b0010;
        push_burst(1'b0, 1, 270, HEIGHT);
        wait_cycle(281);
        req_in = '0;
        wait_cycle(305);
        check("t4_busy_after", 64'(busy_a), 64'(0));

        // Reset at burst cycle 15 aborts at once; tile 0 priority afterwards.
        wait_cycle(310);
        req_in = 4'b0010;
        push_burst(1'b0, 1, 310, 15);
        wait_cycle(311);
        req_in = '0;
        wait_cycle(326);
        #1;
        rst = 1'b0;
        #1;
        check("t5_grant_async", 64'(grant_in), 64'(0));
        check("t5_data_async", 64'(data_in_a), 64'(0));
        check("t5_busy_async", 64'(busy_a), 64'(0));
        check("t5_rd_async", 64'(src_a_rd), 64'(0));
        req_in = 4'b1010;
        wait_cycle(330);
        rst = 1'b1;
        push_burst(1'b0, 1, 330, HEIGHT);
        wait_cycle(331);
        req_in = '0;

        wait_cycle(370);
        check("end_q_a_empty", 64'(q_a.size()), 64'(0));
        check("end_q_b_empty", 64'(q_b.size()), 64'(0));
        check("end_busy", 64'({busy_a, busy_b}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
